// File: rtl/status_reg_pkg.sv
// Shared encodings for the 6502 status register: ALU flag-bus and P bit positions,
// flag-instruction and branch-condition codes.
package status_reg_pkg;

    // Bit indices on the 4-bit ALU flag bus {N,V,Z,C}
    localparam int FLAG_N = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    // Bit positions within the P byte
    localparam int P_N = 7;
    localparam int P_V = 6;
    localparam int P_U = 5;
    localparam int P_B = 4;
    localparam int P_D = 3;
    localparam int P_I = 2;
    localparam int P_Z = 1;
    localparam int P_C = 0;

    typedef enum logic [2:0] {
        FLAG_OP_NONE = 3'd0,
        FLAG_OP_CLC  = 3'd1,
        FLAG_OP_SEC  = 3'd2,
        FLAG_OP_CLI  = 3'd3,
        FLAG_OP_SEI  = 3'd4,
        FLAG_OP_CLV  = 3'd5,
        FLAG_OP_CLD  = 3'd6,
        FLAG_OP_SED  = 3'd7
    } flag_op_e;

    typedef enum logic [2:0] {
        BR_BPL = 3'd0,
        BR_BMI = 3'd1,
        BR_BVC = 3'd2,
        BR_BVS = 3'd3,
        BR_BCC = 3'd4,
        BR_BCS = 3'd5,
        BR_BNE = 3'd6,
        BR_BEQ = 3'd7
    } br_cond_e;

endpackage

// File: rtl/status_reg_branch_cond.sv
// Branch condition evaluator: selects one registered flag and a polarity
// according to the 6502 conditional-branch opcode group.
module branch_cond
    import status_reg_pkg::*;
(
    input  logic [2:0] br_cond,
    input  logic       n_flag,
    input  logic       v_flag,
    input  logic       z_flag,
    input  logic       c_flag,
    output logic       br_taken
);

    always_comb begin
        br_taken = 1'b0;
        case (br_cond_e'(br_cond))
            BR_BPL:  br_taken = ~n_flag;
            BR_BMI:  br_taken =  n_flag;
            BR_BVC:  br_taken = ~v_flag;
            BR_BVS:  br_taken =  v_flag;
            BR_BCC:  br_taken = ~c_flag;
            BR_BCS:  br_taken =  c_flag;
            BR_BNE:  br_taken = ~z_flag;
            BR_BEQ:  br_taken =  z_flag;
            default: br_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_reg.sv
// 6502 processor status register P with delayed IRQ mask and branch evaluation.
// Define STATUS_DECIMAL_EN to implement the D flag; otherwise D reads as 0 (2A03 style).
module status_reg
    import status_reg_pkg::*;
#(
    parameter logic [7:0] RESET_P = 8'h24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] alu_flags,
    input  logic [3:0] flag_upd,
    input  logic       bit_op,
    input  logic [1:0] bit_data,
    input  logic [2:0] flag_op,
    input  logic       p_load,
    input  logic [7:0] p_in,
    input  logic       p_load_now,
    input  logic       instr_boundary,
    input  logic       push_b,
    input  logic [2:0] br_cond,
    output logic [7:0] p_out,
    output logic [7:0] push_byte,
    output logic       carry_flag,
    output logic       irq_mask,
    output logic       br_taken
);

    logic n_q, v_q, i_q, z_q, c_q, irq_q;
    logic n_d, v_d, i_d, z_d, c_d, irq_d;
    logic d_q;

`ifdef STATUS_DECIMAL_EN
    logic d_d;
    logic unused_p_in;
    assign unused_p_in = ^{p_in[P_U], p_in[P_B]};
`else
    logic unused_p_in;
    assign unused_p_in = ^{p_in[P_U], p_in[P_B], p_in[P_D]};
    assign d_q = 1'b0;
`endif

    // ALU writes are applied first so a same-cycle flag_op to the same flag overrides them
    always_comb begin
        n_d = n_q;
        v_d = v_q;
        i_d = i_q;
        z_d = z_q;
        c_d = c_q;
`ifdef STATUS_DECIMAL_EN
        d_d = d_q;
`endif
        if (p_load) begin
            n_d = p_in[P_N];
            v_d = p_in[P_V];
            i_d = p_in[P_I];
            z_d = p_in[P_Z];
            c_d = p_in[P_C];
`ifdef STATUS_DECIMAL_EN
            d_d = p_in[P_D];
`endif
        end else begin
            if (flag_upd[FLAG_N]) n_d = alu_flags[FLAG_N];
            if (flag_upd[FLAG_V]) v_d = alu_flags[FLAG_V];
            if (flag_upd[FLAG_Z]) z_d = alu_flags[FLAG_Z];
            if (flag_upd[FLAG_C]) c_d = alu_flags[FLAG_C];
            if (bit_op) begin
                n_d = bit_data[1];
                v_d = bit_data[0];
            end
            case (flag_op_e'(flag_op))
                FLAG_OP_CLC: c_d = 1'b0;
                FLAG_OP_SEC: c_d = 1'b1;
                FLAG_OP_CLI: i_d = 1'b0;
                FLAG_OP_SEI: i_d = 1'b1;
                FLAG_OP_CLV: v_d = 1'b0;
`ifdef STATUS_DECIMAL_EN
                FLAG_OP_CLD: d_d = 1'b0;
                FLAG_OP_SED: d_d = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // irq_mask samples the pre-edge I at the boundary; RTI bypasses that delay
    always_comb begin
        irq_d = irq_q;
        if (p_load && p_load_now) begin
            irq_d = p_in[P_I];
        end else if (instr_boundary) begin
            irq_d = i_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q   <= RESET_P[P_N];
            v_q   <= RESET_P[P_V];
            i_q   <= RESET_P[P_I];
            z_q   <= RESET_P[P_Z];
            c_q   <= RESET_P[P_C];
            irq_q <= 1'b1;
        end else begin
            n_q   <= n_d;
            v_q   <= v_d;
            i_q   <= i_d;
            z_q   <= z_d;
            c_q   <= c_d;
            irq_q <= irq_d;
        end
    end

`ifdef STATUS_DECIMAL_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q <= RESET_P[P_D];
        end else begin
            d_q <= d_d;
        end
    end
`endif

    assign p_out      = {n_q, v_q, 1'b1, 1'b0,   d_q, i_q, z_q, c_q};
    assign push_byte  = {n_q, v_q, 1'b1, push_b, d_q, i_q, z_q, c_q};
    assign carry_flag = c_q;
    assign irq_mask   = irq_q;

    branch_cond u_branch_cond (
        .br_cond  (br_cond),
        .n_flag   (n_q),
        .v_flag   (v_q),
        .z_flag   (z_q),
        .c_flag   (c_q),
        .br_taken (br_taken)
    );

endmodule

// File: tb/tb_status_reg.sv
// Testbench for status_reg: directed vector table followed by randomized
// stimulus checked against a byte-level model of P.
module tb_status_reg;

`ifdef STATUS_DECIMAL_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] alu_flags, flag_upd;
    logic       bit_op;
    logic [1:0] bit_data;
    logic [2:0] flag_op;
    logic       p_load;
    logic [7:0] p_in;
    logic       p_load_now, instr_boundary, push_b;
    logic [2:0] br_cond;
    logic [7:0] p_out, push_byte;
    logic       carry_flag, irq_mask, br_taken;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    status_reg #(.RESET_P(8'h24)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_flags      (alu_flags),
        .flag_upd       (flag_upd),
        .bit_op         (bit_op),
        .bit_data       (bit_data),
        .flag_op        (flag_op),
        .p_load         (p_load),
        .p_in           (p_in),
        .p_load_now     (p_load_now),
        .instr_boundary (instr_boundary),
        .push_b         (push_b),
        .br_cond        (br_cond),
        .p_out          (p_out),
        .push_byte      (push_byte),
        .carry_flag     (carry_flag),
        .irq_mask       (irq_mask),
        .br_taken       (br_taken)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] alu;
        logic [3:0] upd;
        logic       bop;
        logic [1:0] bd;
        logic [2:0] fop;
        logic       pl;
        logic [7:0] pin;
        logic       pln;
        logic       ib;
        logic       pb;
        logic [2:0] br;
        logic [7:0] exp_p;
        logic [7:0] exp_push;
        logic       exp_c;
        logic       exp_irq;
        logic       exp_br;
    } vec_t;

    vec_t tbl[16];

    // Model state: the architectural P byte (bit5=1, bit4=0) and the IRQ mask
    logic [7:0] mp;
    logic       mirq;

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst_n          = v.rst_n;
        alu_flags      = v.alu;
        flag_upd       = v.upd;
        bit_op         = v.bop;
        bit_data       = v.bd;
        flag_op        = v.fop;
        p_load         = v.pl;
        p_in           = v.pin;
        p_load_now     = v.pln;
        instr_boundary = v.ib;
        push_b         = v.pb;
        br_cond        = v.br;
    endtask

    // Reference: updates the P byte with plain bit arithmetic from the instruction rules
    task automatic model_step();
        int amap[4] = '{0, 1, 6, 7};
        logic [7:0] np;
        logic [7:0] keep;
        if (!rst_n) begin
            mp   = 8'h24;
            mirq = 1'b1;
            return;
        end
        np = mp;
        keep = DEC ? 8'hCF : 8'hC7;
        if (p_load) begin
            np = (p_in & keep) | 8'h20;
        end else begin
            for (int k = 0; k < 4; k++)
                if (flag_upd[k]) np[amap[k]] = alu_flags[k];
            if (bit_op) begin
                np[7] = bit_data[1];
                np[6] = bit_data[0];
            end
            case (flag_op)
                3'd1: np[0] = 1'b0;
                3'd2: np[0] = 1'b1;
                3'd3: np[2] = 1'b0;
                3'd4: np[2] = 1'b1;
                3'd5: np[6] = 1'b0;
                3'd6: if (DEC) np[3] = 1'b0;
                3'd7: if (DEC) np[3] = 1'b1;
                default: ;
            endcase
        end
        if (p_load && p_load_now) mirq = p_in[2];
        else if (instr_boundary)  mirq = mp[2];
        mp = np;
    endtask

    function automatic logic model_br(input logic [7:0] p, input logic [2:0] br);
        int bpos[8] = '{7, 7, 6, 6, 0, 0, 1, 1};
        return p[bpos[br]] == br[0];
    endfunction

    initial begin
        logic [7:0] p_ld_ff, push_ld_ff, p_sed;
        p_ld_ff    = DEC ? 8'hEF : 8'hE7;
        push_ld_ff = DEC ? 8'hFF : 8'hF7;
        p_sed      = DEC ? 8'hEF : 8'hE7;

        //            rst alu      upd      bop bd     fop pl pin    pln ib pb br  exp_p    exp_push  c  irq br
        tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 0, 2'b00, 0, 0, 8'h00, 0, 0, 0, 7, 8'h24,   8'h24,    0, 1, 0};
        tbl[1]  = '{1'b1, 4'b1011, 4'b1111, 0, 2'b00, 0, 0, 8'h00, 0, 0, 1, 1, 8'hA7,   8'hB7,    1, 1, 1};
        tbl[2]  = '{1'b1, 4'b0000, 4'b0000, 0, 2'b00, 0, 0, 8'h00, 0, 0, 0, 6, 8'hA7,   8'hA7,    1, 1, 0};
        tbl[3]  = '{1'b1, 4'b0011, 4'b0011, 0, 2'b00, 1, 0, 8'h00, 0, 0, 0, 7, 8'hA6,   8'hA6,    0, 1, 1};
        tbl[4]  = '{1'b1, 4'b0001, 4'b0001, 1, 2'b11, 0, 0, 8'h00, 0, 0, 0, 3, 8'hE7,   8'hE7,    1, 1, 1};
        tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 0, 2'b00, 3, 0, 8'h00, 0, 1, 0, 5, 8'hE3,   8'hE3,    1, 1, 1};
        tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 0, 2'b00, 0, 0, 8'h00, 0, 0, 0, 4, 8'hE3,   8'hE3,    1, 1, 0};
        tbl[7]  = '{1'b1, 4'b0000, 4'b0000, 0, 2'b00, 0, 0, 8'h00, 0, 1, 0, 0, 8'hE3,   8'hE3,    1, 0, 0};
        tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 0, 2'b00, 0, 1, 8'hFF, 1, 1, 1, 2, p_ld_ff, push_ld_ff, 1, 1, 0};
        tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 0, 2'b00, 6, 0, 8'h00, 0, 0, 0, 7, 8'hE7,   8'hE7,    1, 1, 1};
        tbl[10] = '{1'b1, 4'b0000, 4'b0000, 0, 2'b00, 7, 0, 8'h00, 0, 0, 0, 7, p_sed,   p_sed,    1, 1, 1};
        tbl[11] = '{1'b1, 4'b0000, 4'b0000, 0, 2'b00, 0, 1, 8'h00, 0, 0, 0, 6, 8'h20,   8'h20,    0, 1, 1};
        tbl[12] = '{1'b1, 4'b0000, 4'b0000, 0, 2'b00, 4, 0, 8'h00, 0, 1, 1, 4, 8'h24,   8'h34,    0, 0, 1};
        tbl[13] = '{1'b0, 4'b0000, 4'b0000, 0, 2'b00, 3, 1, 8'h00, 0, 1, 0, 7, 8'h24,   8'h24,    0, 1, 0};
        tbl[14] = '{1'b1, 4'b0000, 4'b0000, 1, 2'b11, 5, 0, 8'h00, 0, 0, 0, 3, 8'hA4,   8'hA4,    0, 1, 0};
        tbl[15] = '{1'b1, 4'b0000, 4'b0000, 0, 2'b00, 0, 1, 8'h00, 1, 1, 0, 1, 8'h20,   8'h20,    0, 0, 0};

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i]);
            @(posedge clk);
            #1;
            chk("p_out",      i, p_out,             tbl[i].exp_p);
            chk("push_byte",  i, push_byte,         tbl[i].exp_push);
            chk("carry_flag", i, {7'd0, carry_flag}, {7'd0, tbl[i].exp_c});
            chk("irq_mask",   i, {7'd0, irq_mask},   {7'd0, tbl[i].exp_irq});
            chk("br_taken",   i, {7'd0, br_taken},   {7'd0, tbl[i].exp_br});
        end

        // Randomized run, begins with a reset so the model starts in lock-step
        mp   = 8'h24;
        mirq = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rst_n          = (n == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
            alu_flags      = 4'($urandom);
            flag_upd       = 4'($urandom);
            bit_op         = ($urandom_range(0, 5) == 0);
            bit_data       = 2'($urandom);
            flag_op        = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
            p_load         = ($urandom_range(0, 7) == 0);
            p_in           = 8'($urandom);
            p_load_now     = 1'($urandom);
            instr_boundary = ($urandom_range(0, 2) == 0);
            push_b         = 1'($urandom);
            br_cond        = 3'($urandom);
            @(posedge clk);
            model_step();
            #1;
            chk("rnd_p_out",     n, p_out,              mp);
            chk("rnd_push_byte", n, push_byte,          mp | {3'b000, push_b, 4'b0000});
            chk("rnd_carry",     n, {7'd0, carry_flag}, {7'd0, mp[0]});
            chk("rnd_irq_mask",  n, {7'd0, irq_mask},   {7'd0, mirq});
            chk("rnd_br_taken",  n, {7'd0, br_taken},   {7'd0, model_br(mp, br_cond)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
